// File: rtl/gcd_req_scheduler.sv
// -----------------------------------------------------------------------------
// gcd_req_scheduler
//
// Shares one W-bit binary-GCD engine between NREQ requesters. A round-robin
// arbiter picks one pending request and latches its operands. If either
// operand is zero, the answer (M|N) goes straight to the response port and
// the engine is not used. Otherwise the operands are loaded into the engine.
// The scheduler then waits for the engine's terminal-count flag, but gives up
// after MAX_CYC RUN cycles. Only one job is in flight at a time.
//
// Ports
//   clk, sync_reset      clock, synchronous active-high reset (shared with engine)
//   req_valid[NREQ]      per-requester request valid
//   req_m / req_n        packed operands, requester i at [i*W +: W]
//   req_ready[NREQ]      one-hot accept strobe, only in the IDLE grant cycle
//   rsp_valid/rsp_ready  response handshake
//   rsp_gcd, rsp_id      result and the index of the requester it belongs to
//   rsp_err              budget expired (rsp_gcd is 0 in that case)
//   busy                 a job is in progress (state != IDLE)
//   eng_M, eng_N         engine operands, held from LOAD through RESP
//   eng_load             one-cycle engine load strobe
//   eng_gcd, eng_tc      engine result and terminal-count flag
// -----------------------------------------------------------------------------
module gcd_req_scheduler #(
  parameter int NREQ    = 4,
  parameter int W       = 8,
  parameter int IDW     = 2,
  parameter int MAX_CYC = 32
) (
  input  logic                clk,
  input  logic                sync_reset,
  input  logic [NREQ-1:0]     req_valid,
  input  logic [NREQ*W-1:0]   req_m,
  input  logic [NREQ*W-1:0]   req_n,
  output logic [NREQ-1:0]     req_ready,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [W-1:0]        rsp_gcd,
  output logic [IDW-1:0]      rsp_id,
  output logic                rsp_err,
  output logic                busy,
  output logic [W-1:0]        eng_M,
  output logic [W-1:0]        eng_N,
  output logic                eng_load,
  input  logic [W-1:0]        eng_gcd,
  input  logic                eng_tc
);

  // The counter needs one spare bit so that MAX_CYC-1 always fits.
  localparam int CW = $clog2(MAX_CYC) + 1;
  localparam logic [CW-1:0]  CYC_LAST = CW'(MAX_CYC - 1);
  localparam logic [IDW-1:0] ID_LAST  = IDW'(NREQ - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2,
    S_RESP = 2'd3
  } state_t;

  // Control state (reset)
  state_t          state, state_nxt;
  logic [IDW-1:0]  rr_ptr, rr_ptr_nxt;
  logic [CW-1:0]   cyc_cnt, cyc_cnt_nxt;
  logic            err, err_nxt;

  // Job data (not reset; every output that shows it is gated by state)
  logic [W-1:0]    op_m, op_n;
  logic [IDW-1:0]  job_id;
  logic [W-1:0]    res, res_nxt;

  // Arbiter
  logic            grant_any;
  logic [IDW-1:0]  grant_idx;
  logic [IDW-1:0]  scan_sel;
  int              scan_idx;
  logic [W-1:0]    grant_m, grant_n;
  logic            load_job;

  // Round-robin scan: the first valid requester at or after rr_ptr, with
  // wrap-around. Explicit wrap keeps this correct for non-power-of-2 NREQ.
  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    scan_idx  = 0;
    scan_sel  = '0;
    for (int k = 0; k < NREQ; k++) begin
      scan_idx = int'(rr_ptr) + k;
      if (scan_idx >= NREQ) begin
        scan_idx = scan_idx - NREQ;
      end
      scan_sel = IDW'(scan_idx);
      if (!grant_any && req_valid[scan_sel]) begin
        grant_any = 1'b1;
        grant_idx = scan_sel;
      end
    end
  end

  assign grant_m = req_m[grant_idx*W +: W];
  assign grant_n = req_n[grant_idx*W +: W];

  // Next-state logic
  always_comb begin
    state_nxt   = state;
    rr_ptr_nxt  = rr_ptr;
    cyc_cnt_nxt = cyc_cnt;
    err_nxt     = err;
    res_nxt     = res;
    load_job    = 1'b0;

    unique case (state)
      S_IDLE: begin
        if (grant_any) begin
          load_job = 1'b1;
          if ((grant_m == '0) || (grant_n == '0)) begin
            // gcd(x,0) = x and gcd(0,0) = 0, so OR-ing the operands gives the answer.
            res_nxt   = grant_m | grant_n;
            err_nxt   = 1'b0;
            state_nxt = S_RESP;
          end else begin
            state_nxt = S_LOAD;
          end
        end
      end

      S_LOAD: begin
        // eng_tc still shows the previous job here, so it is not looked at.
        cyc_cnt_nxt = '0;
        state_nxt   = S_RUN;
      end

      S_RUN: begin
        // tc is checked first, so it wins when it arrives in the last budget cycle.
        if (eng_tc) begin
          res_nxt   = eng_gcd;
          err_nxt   = 1'b0;
          state_nxt = S_RESP;
        end else if (cyc_cnt == CYC_LAST) begin
          res_nxt   = '0;
          err_nxt   = 1'b1;
          state_nxt = S_RESP;
        end else begin
          cyc_cnt_nxt = cyc_cnt + CW'(1);
        end
      end

      S_RESP: begin
        if (rsp_ready) begin
          // The pointer moves just past the requester that was served.
          rr_ptr_nxt = (job_id == ID_LAST) ? '0 : job_id + IDW'(1);
          state_nxt  = S_IDLE;
        end
      end

      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // Control registers
  always_ff @(posedge clk) begin
    if (sync_reset) begin
      state   <= S_IDLE;
      rr_ptr  <= '0;
      cyc_cnt <= '0;
      err     <= 1'b0;
    end else begin
      state   <= state_nxt;
      rr_ptr  <= rr_ptr_nxt;
      cyc_cnt <= cyc_cnt_nxt;
      err     <= err_nxt;
    end
  end

  // Job data registers
  always_ff @(posedge clk) begin
    if (load_job) begin
      op_m   <= grant_m;
      op_n   <= grant_n;
      job_id <= grant_idx;
    end
    res <= res_nxt;
  end

  // Outputs are decoded from state, so all of them are 0 once reset has put
  // the FSM in IDLE. The grant strobe is also held off while reset is
  // asserted, because no accept can happen in that cycle.
  always_comb begin
    req_ready = '0;
    if ((state == S_IDLE) && grant_any && !sync_reset) begin
      req_ready = NREQ'(1) << grant_idx;
    end
  end

  assign busy      = (state != S_IDLE);
  assign eng_load  = (state == S_LOAD);
  assign eng_M     = busy ? op_m : '0;
  assign eng_N     = busy ? op_n : '0;
  assign rsp_valid = (state == S_RESP);
  assign rsp_gcd   = rsp_valid ? res    : '0;
  assign rsp_id    = rsp_valid ? job_id : '0;
  assign rsp_err   = rsp_valid & err;

endmodule
